mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_if.sv | 31 +++
 rtl/mul_div_unit.sv | 121 ++++++++++++
 tb/tb_mul_div_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply-divide unit.
// The master (pipeline) drives requests; the slave (unit) returns HI/LO and status.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             start__i;
    logic [1:0]       op__i;
    logic [WIDTH-1:0] dataA__i;
    logic [WIDTH-1:0] dataB__i;
    logic             cancel__i;
    logic             hiWrite__i;
    logic             loWrite__i;
    logic [WIDTH-1:0] hi__o;
    logic [WIDTH-1:0] lo__o;
    logic             busy__o;
    logic             done__o;
    logic             divByZero__o;
    logic [1:0]       state;

    // start__i is a request sampled only while busy__o is low; there is no ready
    // back-pressure, a start seen while busy is dropped. done__o pulses one cycle.
    modport master (
        output start__i, op__i, dataA__i, dataB__i, cancel__i, hiWrite__i, loWrite__i,
        input  hi__o, lo__o, busy__o, done__o, divByZero__o, state
    );

    modport slave (
        input  start__i, op__i, dataA__i, dataB__i, cancel__i, hiWrite__i, loWrite__i,
        output hi__o, lo__o, busy__o, done__o, divByZero__o, state
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign correction applied on the way out.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input logic     clock__i,
    input logic     reset__i,
    mul_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               mul_r;
    logic               neg_hi;
    logic               neg_lo;
    logic               dz;
    logic [WIDTH-1:0]   m;
    logic [2*WIDTH:0]   p;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;
    logic               dbz;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               b_zero;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        a_neg     = bus.op__i[0] & bus.dataA__i[WIDTH-1];
        b_neg     = bus.op__i[0] & bus.dataB__i[WIDTH-1];
        a_mag     = a_neg ? -bus.dataA__i : bus.dataA__i;
        b_mag     = b_neg ? -bus.dataB__i : bus.dataB__i;
        b_zero    = (bus.dataB__i == '0);
        // p holds {carry, upper half, lower half}; for divide the upper half is the
        // partial remainder and the lower half shifts dividend bits out, quotient in.
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m};
        div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        prod      = neg_hi ? -p[2*WIDTH-1:0] : p[2*WIDTH-1:0];
        quot      = neg_lo ? -p[WIDTH-1:0] : p[WIDTH-1:0];
        rem       = neg_hi ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock__i) begin
        if (reset__i) begin
            state  <= IDLE;
            cnt    <= '0;
            mul_r  <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            dz     <= 1'b0;
            m      <= '0;
            p      <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            done <= 1'b0;
            dbz  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hiWrite__i) hi <= bus.dataA__i;
                    if (bus.loWrite__i) lo <= bus.dataA__i;
                    if (bus.start__i && !bus.cancel__i) begin
                        mul_r  <= ~bus.op__i[1];
                        cnt    <= '0;
                        dz     <= bus.op__i[1] & b_zero;
                        m      <= bus.op__i[1] ? b_mag : a_mag;
                        p      <= {{(WIDTH+1){1'b0}}, (bus.op__i[1] ? a_mag : b_mag)};
                        neg_hi <= bus.op__i[1] ? a_neg : (a_neg ^ b_neg);
                        neg_lo <= a_neg ^ b_neg;
                        state  <= (bus.op__i[1] && b_zero) ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (bus.cancel__i) begin
                        state <= IDLE;
                    end else begin
                        p   <= mul_r ? {1'b0, mul_sum, p[WIDTH-1:1]}
                                     : {1'b0, div_rem, p[WIDTH-2:0], ~div_diff[WIDTH]};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!bus.cancel__i) begin
                        done <= 1'b1;
                        dbz  <= dz;
                        if (!dz) begin
                            hi <= mul_r ? prod[2*WIDTH-1:WIDTH] : rem;
                            lo <= mul_r ? prod[WIDTH-1:0] : quot;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi__o        = hi;
    assign bus.lo__o        = lo;
    assign bus.busy__o      = (state != IDLE);
    assign bus.done__o      = done;
    assign bus.divByZero__o = dbz;
    assign bus.state        = state;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: latency, signed/unsigned results,
// divide by zero, ignored strobes while busy, cancel and reset mid-operation.
module tb_mul_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    mul_div_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clock__i(clk),
        .reset__i(rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and waits for done__o (bounded); lat counts cycles after
    // the accepting edge, so lat==1 is cycle k+1.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cycles, output logic saw_dbz,
                          output logic held);
        logic [W-1:0] hi0;
        logic [W-1:0] lo0;
        hi0 = bus.hi__o;
        lo0 = bus.lo__o;
        bus.op__i    = op;
        bus.dataA__i = a;
        bus.dataB__i = b;
        bus.start__i = 1'b1;
        tick();
        bus.start__i = 1'b0;
        lat = 1;
        busy_cycles = 0;
        held = 1'b1;
        while (!bus.done__o && lat < 200) begin
            if (bus.busy__o) busy_cycles++;
            if (bus.hi__o !== hi0 || bus.lo__o !== lo0) held = 1'b0;
            tick();
            lat++;
        end
        saw_dbz = bus.done__o & bus.divByZero__o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total += 5;
        if (bus.hi__o !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi__o); end
        if (bus.lo__o !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo__o); end
        if (bus.busy__o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy__o); end
        if (bus.done__o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done__o); end
        if (bus.divByZero__o !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b exp=0", bus.divByZero__o); end
    endtask

    task automatic test_mult();
        int lat, bc;
        logic dzf, held;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bc, dzf, held);
        total += 6;
        if (lat !== 34) begin bad++; $display("FAIL mult_latency got=%0d exp=34", lat); end
        if (bc !== 33) begin bad++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
        if (held !== 1'b1) begin bad++; $display("FAIL mult_hilo_held got=%b exp=1", held); end
        if (dzf !== 1'b0) begin bad++; $display("FAIL mult_dbz got=%b exp=0", dzf); end
        if (bus.hi__o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", bus.hi__o); end
        if (bus.lo__o !== 32'hFFFF_FFF1) begin bad++; $display("FAIL mult_lo got=%h exp=fffffff1", bus.lo__o); end
    endtask

    task automatic test_multu();
        int lat, bc;
        logic dzf, held;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dzf, held);
        total += 2;
        if (bus.hi__o !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi__o); end
        if (bus.lo__o !== 32'h0000_0001) begin bad++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo__o); end
    endtask

    task automatic test_div();
        int lat, bc;
        logic dzf, held;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc, dzf, held);
        total += 3;
        if (lat !== 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", lat); end
        if (bus.lo__o !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", bus.lo__o); end
        if (bus.hi__o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", bus.hi__o); end
        run_op(2'b10, 32'd7, 32'd2, lat, bc, dzf, held);
        total += 2;
        if (bus.lo__o !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h exp=3", bus.lo__o); end
        if (bus.hi__o !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h exp=1", bus.hi__o); end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dzf, held);
        total += 3;
        if (bus.lo__o !== 32'h8000_0000) begin bad++; $display("FAIL divmin_lo got=%h exp=80000000", bus.lo__o); end
        if (bus.hi__o !== 32'h0) begin bad++; $display("FAIL divmin_hi got=%h exp=0", bus.hi__o); end
        if (dzf !== 1'b0) begin bad++; $display("FAIL divmin_dbz got=%b exp=0", dzf); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        logic dzf, held;
        bus.dataA__i   = 32'h11;
        bus.hiWrite__i = 1'b1;
        tick();
        bus.hiWrite__i = 1'b0;
        bus.dataA__i   = 32'h22;
        bus.loWrite__i = 1'b1;
        tick();
        bus.loWrite__i = 1'b0;
        total += 2;
        if (bus.hi__o !== 32'h11) begin bad++; $display("FAIL mthi got=%h exp=11", bus.hi__o); end
        if (bus.lo__o !== 32'h22) begin bad++; $display("FAIL mtlo got=%h exp=22", bus.lo__o); end
        run_op(2'b10, 32'd9, 32'd0, lat, bc, dzf, held);
        total += 5;
        if (lat !== 2) begin bad++; $display("FAIL dz_latency got=%0d exp=2", lat); end
        if (bc !== 1) begin bad++; $display("FAIL dz_busy_cycles got=%0d exp=1", bc); end
        if (dzf !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b exp=1", dzf); end
        if (bus.hi__o !== 32'h11) begin bad++; $display("FAIL dz_hi got=%h exp=11", bus.hi__o); end
        if (bus.lo__o !== 32'h22) begin bad++; $display("FAIL dz_lo got=%h exp=22", bus.lo__o); end
    endtask

    task automatic test_cancel();
        int dones;
        bus.op__i    = 2'b01;
        bus.dataA__i = 32'd3;
        bus.dataB__i = 32'd4;
        bus.start__i = 1'b1;
        tick();
        bus.start__i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus.start__i   = 1'b1;
        bus.hiWrite__i = 1'b1;
        bus.dataA__i   = 32'hDEAD;
        tick();
        bus.start__i   = 1'b0;
        bus.hiWrite__i = 1'b0;
        total += 2;
        if (bus.hi__o !== 32'h11) begin bad++; $display("FAIL busy_mthi got=%h exp=11", bus.hi__o); end
        if (bus.busy__o !== 1'b1) begin bad++; $display("FAIL busy_mid got=%b exp=1", bus.busy__o); end
        for (int i = 0; i < 4; i++) tick();
        bus.cancel__i = 1'b1;
        tick();
        bus.cancel__i = 1'b0;
        total += 1;
        if (bus.busy__o !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b exp=0", bus.busy__o); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done__o || bus.busy__o) dones++;
            tick();
        end
        total += 3;
        if (dones !== 0) begin bad++; $display("FAIL cancel_activity got=%0d exp=0", dones); end
        if (bus.hi__o !== 32'h11) begin bad++; $display("FAIL cancel_hi got=%h exp=11", bus.hi__o); end
        if (bus.lo__o !== 32'h22) begin bad++; $display("FAIL cancel_lo got=%h exp=22", bus.lo__o); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic dzf, held;
        run_op(2'b00, 32'd3, 32'd4, lat, bc, dzf, held);
        total += 2;
        if (bus.lo__o !== 32'd12) begin bad++; $display("FAIL b2b_mul_lo got=%h exp=c", bus.lo__o); end
        if (bus.hi__o !== 32'd0) begin bad++; $display("FAIL b2b_mul_hi got=%h exp=0", bus.hi__o); end
        run_op(2'b10, 32'd100, 32'd7, lat, bc, dzf, held);
        total += 3;
        if (lat !== 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", lat); end
        if (bus.lo__o !== 32'd14) begin bad++; $display("FAIL b2b_div_lo got=%h exp=e", bus.lo__o); end
        if (bus.hi__o !== 32'd2) begin bad++; $display("FAIL b2b_div_hi got=%h exp=2", bus.hi__o); end
    endtask

    task automatic test_reset_flight();
        int dones;
        bus.op__i    = 2'b11;
        bus.dataA__i = 32'd1000;
        bus.dataB__i = 32'd3;
        bus.start__i = 1'b1;
        tick();
        bus.start__i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 3;
        if (bus.busy__o !== 1'b0) begin bad++; $display("FAIL rstfl_busy got=%b exp=0", bus.busy__o); end
        if (bus.hi__o !== 32'h0) begin bad++; $display("FAIL rstfl_hi got=%h exp=0", bus.hi__o); end
        if (bus.lo__o !== 32'h0) begin bad++; $display("FAIL rstfl_lo got=%h exp=0", bus.lo__o); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done__o) dones++;
            tick();
        end
        total += 1;
        if (dones !== 0) begin bad++; $display("FAIL rstfl_done got=%0d exp=0", dones); end
    endtask

    initial begin
        bus.start__i   = 1'b0;
        bus.op__i      = 2'b00;
        bus.dataA__i   = '0;
        bus.dataB__i   = '0;
        bus.cancel__i  = 1'b0;
        bus.hiWrite__i = 1'b0;
        bus.loWrite__i = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_reset_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
